// File: rtl/tlc_phase_sequencer.sv
// Traffic-light phase sequencer: cycles each approach through ALL_RED -> GREEN -> YELLOW,
// with per-phase pedestrian green extension and a countdown display with blink request.
module tlc_phase_sequencer #(
    parameter int unsigned NUM_PHASES      = 2,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned RED_CLEAR_TICKS = 2,
    parameter int unsigned GREEN_TICKS     = 9,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned PED_EXTRA_TICKS = 4,
    parameter int unsigned BLINK_THRESH    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] ped_req,
    output logic [NUM_PHASES-1:0] red_led,
    output logic [NUM_PHASES-1:0] yellow_led,
    output logic [NUM_PHASES-1:0] green_led,
    output logic [1:0]            active_phase,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      display_digit,
    output logic                  blinking_enable,
    output logic [NUM_PHASES-1:0] ped_pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ALL_RED = 2'b01,
        ST_GREEN   = 2'b10,
        ST_YELLOW  = 2'b11
    } state_e;

    // All-ones on the display means blank, so no duration may reach it.
    localparam int unsigned MAX_DUR = (CNT_W >= 2 && CNT_W <= 16) ? ((32'd1 << CNT_W) - 32'd2) : 32'd0;
    localparam bit PARAMS_OK =
        (NUM_PHASES >= 2) && (NUM_PHASES <= 4) &&
        (CNT_W >= 2) && (CNT_W <= 16) &&
        (RED_CLEAR_TICKS >= 1) && (RED_CLEAR_TICKS <= MAX_DUR) &&
        (GREEN_TICKS >= 1) && (YELLOW_TICKS >= 1) && (YELLOW_TICKS <= MAX_DUR) &&
        (PED_EXTRA_TICKS >= 1) && ((GREEN_TICKS + PED_EXTRA_TICKS) <= MAX_DUR);

    if (!PARAMS_OK) begin : g_bad_params
        $error("tlc_phase_sequencer: parameter out of range");
    end

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RED_CNT       = CNT_W'(RED_CLEAR_TICKS);
    localparam logic [CNT_W-1:0] GREEN_CNT     = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] GREEN_PED_CNT = CNT_W'(GREEN_TICKS + PED_EXTRA_TICKS);
    localparam logic [CNT_W-1:0] YELLOW_CNT    = CNT_W'(YELLOW_TICKS);
    localparam logic [1:0]       LAST_PHASE    = 2'(NUM_PHASES - 1);

    state_e                  state_q, state_d;
    logic [1:0]              active_phase_q, active_phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_PHASES-1:0]   ped_pending_q, ped_pending_d;

    logic [NUM_PHASES-1:0]   phase_mask_s;
    logic                    ped_hit_s;
    logic [1:0]              next_phase_s;
    logic                    blink_win_s;

    // Per-phase helpers derived from the current phase and count.
    always_comb begin
        phase_mask_s = {{(NUM_PHASES-1){1'b0}}, 1'b1} << active_phase_q;
        ped_hit_s    = |(ped_pending_q & phase_mask_s);
        next_phase_s = (active_phase_q == LAST_PHASE) ? 2'd0 : (active_phase_q + 2'd1);
        blink_win_s  = (cnt_q != '0) && (32'(cnt_q) <= BLINK_THRESH);
    end

    // Next-state logic; start=0 outranks any expiry, and a new request outranks the clear.
    always_comb begin
        state_d        = state_q;
        active_phase_d = active_phase_q;
        cnt_d          = cnt_q;
        ped_pending_d  = ped_pending_q | ped_req;
        if (!start) begin
            state_d        = ST_IDLE;
            active_phase_d = 2'd0;
            cnt_d          = '0;
        end else if (state_q == ST_IDLE) begin
            state_d        = ST_ALL_RED;
            active_phase_d = 2'd0;
            cnt_d          = RED_CNT;
        end else if (!tick) begin
            cnt_d = cnt_q;
        end else if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    state_d = ST_GREEN;
                    cnt_d   = ped_hit_s ? GREEN_PED_CNT : GREEN_CNT;
                end
                ST_GREEN: begin
                    state_d       = ST_YELLOW;
                    cnt_d         = YELLOW_CNT;
                    ped_pending_d = (ped_pending_q & ~phase_mask_s) | ped_req;
                end
                ST_YELLOW: begin
                    state_d        = ST_ALL_RED;
                    cnt_d          = RED_CNT;
                    active_phase_d = next_phase_s;
                end
                default: begin
                    state_d        = ST_IDLE;
                    cnt_d          = '0;
                    active_phase_d = 2'd0;
                end
            endcase
        end
    end

    // State, phase, countdown and pedestrian latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            active_phase_q <= 2'd0;
            cnt_q          <= '0;
            ped_pending_q  <= '0;
        end else begin
            state_q        <= state_d;
            active_phase_q <= active_phase_d;
            cnt_q          <= cnt_d;
            ped_pending_q  <= ped_pending_d;
        end
    end

    // Lamp and display decode straight from the registers.
    always_comb begin
        red_led         = '0;
        yellow_led      = '0;
        green_led       = '0;
        display_digit   = '1;
        blinking_enable = 1'b0;
        case (state_q)
            ST_ALL_RED: begin
                red_led         = '1;
                display_digit   = cnt_q;
                blinking_enable = blink_win_s;
            end
            ST_GREEN: begin
                green_led       = phase_mask_s;
                red_led         = ~phase_mask_s;
                display_digit   = cnt_q;
                blinking_enable = blink_win_s;
            end
            ST_YELLOW: begin
                yellow_led      = phase_mask_s;
                red_led         = ~phase_mask_s;
                display_digit   = cnt_q;
                blinking_enable = 1'b0;
            end
            default: begin
                red_led         = '0;
                display_digit   = '1;
                blinking_enable = 1'b0;
            end
        endcase
    end

    assign state        = state_q;
    assign active_phase = active_phase_q;
    assign ped_pending  = ped_pending_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Self-checking bench for tlc_phase_sequencer: reset/start table, directed corner
// sequences and randomized stimulus against a tick-level reference model.
module tb_tlc_phase_sequencer;

    localparam int NP    = 3;
    localparam int RED   = 2;
    localparam int GRN   = 5;
    localparam int YEL   = 2;
    localparam int PED   = 4;
    localparam int BLINK = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] ped_req = 3'b000;
    logic [2:0] red, yel, grn, pend;
    logic [1:0] aph, dut_state;
    logic [3:0] disp;
    logic       blink;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 all-red, 2 green, 3 yellow; rem = ticks left in state.
    int m_st = 0, m_ph = 0, m_rem = 0, m_ped = 0;

    always #5 clk = ~clk;

    tlc_phase_sequencer #(
        .NUM_PHASES(NP), .CNT_W(4), .RED_CLEAR_TICKS(RED), .GREEN_TICKS(GRN),
        .YELLOW_TICKS(YEL), .PED_EXTRA_TICKS(PED), .BLINK_THRESH(BLINK)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .ped_req(ped_req),
        .red_led(red), .yellow_led(yel), .green_led(grn), .active_phase(aph),
        .state(dut_state), .display_digit(disp), .blinking_enable(blink),
        .ped_pending(pend)
    );

    typedef struct {
        bit       st;
        bit       tk;
        bit [2:0] pr;
        int e_state, e_phase, e_disp, e_blink, e_red, e_yel, e_grn, e_ped;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_rem = 0; m_ped = 0;
    endtask

    task automatic model_step(input bit st, input bit tk, input bit [2:0] pr);
        int nped;
        nped = m_ped | int'(pr);
        if (!st) begin
            m_st = 0; m_ph = 0; m_rem = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_ph = 0; m_rem = RED;
        end else if (tk) begin
            if (m_rem > 1) m_rem = m_rem - 1;
            else if (m_st == 1) begin
                m_st = 2;
                m_rem = ((m_ped >> m_ph) & 1) ? GRN + PED : GRN;
            end else if (m_st == 2) begin
                m_st = 3; m_rem = YEL;
                nped = (m_ped & ~(1 << m_ph)) | int'(pr);
            end else begin
                m_st = 1; m_rem = RED; m_ph = (m_ph + 1) % NP;
            end
        end
        m_ped = nped;
    endtask

    task automatic check_model(input string tag);
        int own, e_red, e_yel, e_grn;
        own   = 1 << m_ph;
        e_red = (m_st == 0) ? 0 : (m_st == 1) ? 7 : (7 & ~own);
        e_yel = (m_st == 3) ? own : 0;
        e_grn = (m_st == 2) ? own : 0;
        chk({tag, ".state"}, int'(dut_state), m_st);
        chk({tag, ".phase"}, int'(aph), m_ph);
        chk({tag, ".red"}, int'(red), e_red);
        chk({tag, ".yellow"}, int'(yel), e_yel);
        chk({tag, ".green"}, int'(grn), e_grn);
        chk({tag, ".display"}, int'(disp), (m_st == 0) ? 15 : m_rem);
        chk({tag, ".blink"}, int'(blink),
            ((m_st == 1 || m_st == 2) && m_rem >= 1 && m_rem <= BLINK) ? 1 : 0);
        chk({tag, ".ped_pending"}, int'(pend), m_ped);
        if (m_st != 0)
            chk({tag, ".one_lamp"},
                ((red | yel | grn) == 3'b111 && (red & yel) == 3'b000 &&
                 (red & grn) == 3'b000 && (yel & grn) == 3'b000) ? 1 : 0, 1);
    endtask

    task automatic drive_step(input bit st, input bit tk, input bit [2:0] pr);
        start = st; tick = tk; ped_req = pr;
        @(posedge clk);
        #1;
        model_step(st, tk, pr);
        tick = 1'b0; ped_req = 3'b000;
    endtask

    task automatic step(input bit st, input bit tk, input bit [2:0] pr, input string tag);
        drive_step(st, tk, pr);
        check_model(tag);
    endtask

    // Tick along until the model reaches the target (negative = don't care), bounded.
    task automatic advance_until(input int ts, input int tp, input int tc, input string tag);
        int n;
        bit hit;
        n = 0;
        hit = (m_st == ts) && (tp < 0 || m_ph == tp) && (tc < 0 || m_rem == tc);
        while (!hit && n < 60) begin
            step(1'b1, 1'b1, 3'b000, tag);
            n++;
            hit = (m_st == ts) && (tp < 0 || m_ph == tp) && (tc < 0 || m_rem == tc);
        end
        chk({tag, ".reached"}, hit ? 1 : 0, 1);
    endtask

    initial begin
        // inputs {st,tk,pr} -> {state,phase,disp,blink,red,yel,grn,ped}
        tv[0]  = '{1'b0, 1'b0, 3'b000, 0, 0, 15, 0, 0, 0, 0, 0};
        tv[1]  = '{1'b1, 1'b0, 3'b000, 1, 0, 2, 1, 7, 0, 0, 0};
        tv[2]  = '{1'b1, 1'b1, 3'b000, 1, 0, 1, 1, 7, 0, 0, 0};
        tv[3]  = '{1'b1, 1'b1, 3'b000, 2, 0, 5, 0, 6, 0, 1, 0};
        tv[4]  = '{1'b1, 1'b0, 3'b000, 2, 0, 5, 0, 6, 0, 1, 0};
        tv[5]  = '{1'b1, 1'b1, 3'b000, 2, 0, 4, 0, 6, 0, 1, 0};
        tv[6]  = '{1'b1, 1'b1, 3'b000, 2, 0, 3, 1, 6, 0, 1, 0};
        tv[7]  = '{1'b1, 1'b1, 3'b000, 2, 0, 2, 1, 6, 0, 1, 0};
        tv[8]  = '{1'b1, 1'b1, 3'b000, 2, 0, 1, 1, 6, 0, 1, 0};
        tv[9]  = '{1'b1, 1'b1, 3'b000, 3, 0, 2, 0, 6, 1, 0, 0};
        tv[10] = '{1'b1, 1'b1, 3'b000, 3, 0, 1, 0, 6, 1, 0, 0};
        tv[11] = '{1'b1, 1'b1, 3'b000, 1, 1, 2, 1, 7, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.state", int'(dut_state), 0);
        chk("reset.display", int'(disp), 15);
        chk("reset.lamps", int'({red, yel, grn}), 0);
        model_reset();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive_step(tv[i].st, tv[i].tk, tv[i].pr);
            chk($sformatf("tv%0d.state", i), int'(dut_state), tv[i].e_state);
            chk($sformatf("tv%0d.phase", i), int'(aph), tv[i].e_phase);
            chk($sformatf("tv%0d.display", i), int'(disp), tv[i].e_disp);
            chk($sformatf("tv%0d.blink", i), int'(blink), tv[i].e_blink);
            chk($sformatf("tv%0d.red", i), int'(red), tv[i].e_red);
            chk($sformatf("tv%0d.yellow", i), int'(yel), tv[i].e_yel);
            chk($sformatf("tv%0d.green", i), int'(grn), tv[i].e_grn);
            chk($sformatf("tv%0d.ped", i), int'(pend), tv[i].e_ped);
        end

        // Remaining 18 of 27 ticks bring the sequence back to phase 0.
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 3'b000, "cycle27");
        chk("wrap.state", int'(dut_state), 1);
        chk("wrap.phase", int'(aph), 0);

        // Pedestrian request during phase 0 green extends phase 1 green to 9.
        advance_until(2, 0, -1, "ped_to_g0");
        step(1'b1, 1'b0, 3'b010, "ped_pulse");
        chk("ped_pulse.latched", int'(pend), 2);
        advance_until(2, 1, -1, "ped_to_g1");
        chk("ped_g1.display9", int'(disp), 9);
        for (int k = 8; k >= 1; k--) begin
            step(1'b1, 1'b1, 3'b000, "ped_g1");
            chk($sformatf("ped_g1.display%0d", k), int'(disp), k);
        end
        step(1'b1, 1'b1, 3'b000, "ped_y1");
        chk("ped_y1.state", int'(dut_state), 3);
        chk("ped_y1.cleared", int'(pend[1]), 0);

        // Request coincident with the clearing edge keeps the bit set.
        advance_until(2, 1, 1, "setwin_g1");
        step(1'b1, 1'b1, 3'b010, "setwin");
        chk("setwin.state", int'(dut_state), 3);
        chk("setwin.ped1", int'(pend[1]), 1);

        // start dropped together with the expiring tick wins over the transition.
        advance_until(2, -1, 1, "stop_g");
        step(1'b0, 1'b1, 3'b000, "stop");
        chk("stop.state", int'(dut_state), 0);
        chk("stop.lamps", int'({red, yel, grn}), 0);
        chk("stop.display", int'(disp), 15);
        chk("stop.ped_kept", int'(pend[1]), 1);

        // Asynchronous reset mid-yellow, between clock edges.
        step(1'b1, 1'b0, 3'b000, "restart");
        advance_until(3, -1, -1, "to_yellow");
        #2;
        reset = 1'b1;
        #1;
        chk("async.state", int'(dut_state), 0);
        chk("async.phase", int'(aph), 0);
        chk("async.lamps", int'({red, yel, grn}), 0);
        chk("async.display", int'(disp), 15);
        chk("async.blink", int'(blink), 0);
        chk("async.ped", int'(pend), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 3'b000, "post_reset");
        chk("post_reset.state", int'(dut_state), 1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 500; i++) begin
            bit       st, tk;
            bit [2:0] pr;
            st = ($urandom_range(0, 24) != 0);
            tk = ($urandom_range(0, 1) == 1);
            pr = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(st, tk, pr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
